// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared state encoding and default word width
package piso_serializer_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load/ready handshake and serial output bundle
interface piso_serializer_if #(parameter int WIDTH = piso_serializer_pkg::DEFAULT_WIDTH);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             Q;
  logic             valid;
  logic             done;
  modport master (output load, din, input ready, Q, valid, done);
  modport slave (input load, din, output ready, Q, valid, done);
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// piso_serializer_bit_counter: up-counter with clear, enable and terminal-count flag
module piso_serializer_bit_counter #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign tc  = cnt_q == CW'(WIDTH - 1);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with load/ready handshake
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              reset,
  piso_serializer_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             q_q, q_d, valid_q, valid_d, done_q, done_d, ready_q, ready_d;
  logic [CW-1:0]    cnt;
  logic             tc, accept, shifting;
  function automatic logic pick(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? x[WIDTH-1] : x[0];
  endfunction
  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] x);
    return MSB_FIRST ? x << 1 : x >> 1;
  endfunction
  piso_serializer_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk), .reset(reset), .clr(accept), .en(shifting), .cnt(cnt), .tc(tc)
  );
  // The first bit is presented on the accept edge, so sr_q always holds the bits still to go.
  always_comb begin
    accept   = state_q == IDLE && bus.load;
    shifting = state_q == SHIFT && !tc;
    state_d  = accept ? SHIFT : (state_q == SHIFT && tc) ? IDLE : state_q;
    sr_d     = accept ? adv(bus.din) : shifting ? adv(sr_q) : sr_q;
    q_d      = accept ? pick(bus.din) : shifting ? pick(sr_q) : 1'b0;
    valid_d  = accept || shifting;
    done_d   = shifting && cnt == CW'(WIDTH - 2);
    ready_d  = state_d == IDLE;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      q_q     <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  assign bus.Q     = q_q;
  assign bus.valid = valid_q;
  assign bus.done  = done_q;
  assign bus.ready = ready_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of handshake, bit order, reset and back-to-back words
module tb_piso_serializer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  piso_serializer_if #(.WIDTH(8)) if_m ();
  piso_serializer_if #(.WIDTH(8)) if_l ();
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(if_m.slave));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(if_l.slave));
  always #5 clk = ~clk;
  // Observed vectors are {ready, valid, done, Q}.
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [3:0] obs;
    reset = 1'b0;
    if_m.load = 1'b1;
    if_m.din = 8'hA5;
    if_l.load = 1'b1;
    if_l.din = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      step();
      obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
      n_checks++;
      if (obs !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_msb[%0d]: got %b expected 1000", i, obs);
      end
      obs = {if_l.ready, if_l.valid, if_l.done, if_l.Q};
      n_checks++;
      if (obs !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_lsb[%0d]: got %b expected 1000", i, obs);
      end
    end
    reset = 1'b1;
    if_m.load = 1'b0;
    if_l.load = 1'b0;
    step();
    obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_no_accept: got %b expected 1000", obs);
    end
  endtask
  task automatic test_msb_first();
    logic [7:0] w;
    logic [3:0] obs, exp;
    w = 8'hA5;
    if_m.load = 1'b1;
    if_m.din = w;
    step();
    if_m.load = 1'b0;
    if_m.din = 8'h00;
    for (int k = 0; k < 8; k++) begin
      exp = {1'b0, 1'b1, k == 7, w[7-k]};
      obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL msb_bit[%0d]: got %b expected %b", k, obs, exp);
      end
      step();
    end
    obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL msb_ready_after: got %b expected 1000", obs);
    end
  endtask
  task automatic test_lsb_first();
    logic [7:0] w;
    logic [3:0] obs, exp;
    w = 8'h0F;
    if_l.load = 1'b1;
    if_l.din = w;
    step();
    if_l.load = 1'b0;
    if_l.din = 8'hF0;
    for (int k = 0; k < 8; k++) begin
      exp = {1'b0, 1'b1, k == 7, w[k]};
      obs = {if_l.ready, if_l.valid, if_l.done, if_l.Q};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL lsb_bit[%0d]: got %b expected %b", k, obs, exp);
      end
      step();
    end
    obs = {if_l.ready, if_l.valid, if_l.done, if_l.Q};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL lsb_ready_after: got %b expected 1000", obs);
    end
  endtask
  task automatic test_busy_load();
    logic [3:0] obs, exp;
    if_m.load = 1'b1;
    if_m.din = 8'h00;
    step();
    if_m.din = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      exp = {1'b0, 1'b1, k == 7, 1'b0};
      obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL busy_zero[%0d]: got %b expected %b", k, obs, exp);
      end
      step();
    end
    obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL busy_gap: got %b expected 1000", obs);
    end
    step();
    if_m.load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = {1'b0, 1'b1, k == 7, 1'b1};
      obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL busy_ones[%0d]: got %b expected %b", k, obs, exp);
      end
      step();
    end
  endtask
  task automatic test_mid_reset();
    logic [7:0] w;
    logic [3:0] obs, exp;
    w = 8'hC3;
    if_m.load = 1'b1;
    if_m.din = w;
    step();
    if_m.load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp = {1'b0, 1'b1, 1'b0, w[7-k]};
      obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL abort_bit[%0d]: got %b expected %b", k, obs, exp);
      end
      if (k < 2) step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_idle: got %b expected 1000", obs);
    end
    w = 8'h3C;
    if_m.load = 1'b1;
    if_m.din = w;
    step();
    if_m.load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = {1'b0, 1'b1, k == 7, w[7-k]};
      obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reload_bit[%0d]: got %b expected %b", k, obs, exp);
      end
      // A glitch on reset between edges must not disturb the word.
      if (k == 2) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
      step();
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] w;
    logic [3:0] obs, exp;
    int         ph;
    w = 8'h96;
    if_m.load = 1'b1;
    if_m.din = w;
    for (int i = 0; i < 40; i++) begin
      step();
      ph = i % 9;
      exp = (ph == 8) ? 4'b1000 : {1'b0, 1'b1, ph == 7, w[7-ph]};
      obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %b expected %b", i, obs, exp);
      end
    end
    if_m.load = 1'b0;
    repeat (10) step();
    obs = {if_m.ready, if_m.valid, if_m.done, if_m.Q};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL b2b_drain: got %b expected 1000", obs);
    end
  endtask
  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_busy_load();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, 8, number of bits per serialized word (legal range 2..32).
REQ-002 Parameter: MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.
REQ-003 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 Port: load  input  1  request to accept din; honoured only when ready=1.
REQ-006 Port: din  input  WIDTH  parallel word to serialize.
REQ-007 Port: ready  output  1  block is idle and will accept load in this cycle.
REQ-008 Port: Q  output  1  serial data bit, registered.
REQ-009 Port: valid  output  1  Q carries a bit of the current word, registered.
REQ-010 Port: done  output  1  one-cycle pulse coincident with the last bit of a word, registered.

Function
REQ-011 FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-012 In IDLE: ready=1, valid=0, done=0, Q=0.
REQ-013 IDLE->SHIFT on a rising edge with load=1; din SHALL be captured into the shift register on that same edge.
REQ-014 Handshake: a load is accepted at edge N. First bit on Q with valid=1 during cycle N+1. Bit k (k=0..WIDTH-1) during cycle N+1+k.
REQ-015 Bit order: MSB_FIRST=1 sends din[WIDTH-1] down to din[0]; MSB_FIRST=0 sends din[0] up to din[WIDTH-1].
REQ-016 In SHIFT: ready=0, and load SHALL be ignored; din changes after capture SHALL NOT affect the word in flight.
REQ-017 Bit counter: width ceil(log2(WIDTH)). Cleared on accept, incremented once per SHIFT cycle, no wrap-around beyond WIDTH-1.
REQ-018 When the counter reaches WIDTH-1: done=1 for that cycle only, and the FSM returns to IDLE on the next edge.
REQ-019 After the last bit, ready SHALL be 1 in cycle N+WIDTH+1, so the fastest back-to-back rate is one word per WIDTH+1 cycles.
REQ-020 Between words, Q and valid SHALL be 0 for at least one cycle.
REQ-021 load=1 held continuously SHALL start a new word at every IDLE cycle, and never while in SHIFT.
REQ-022 Asynchronous changes of load or din between clock edges SHALL have no effect until the next rising edge.

Reset
REQ-023 reset=0 at a rising edge SHALL force IDLE, counter=0, shift register=0, Q=0, valid=0, done=0, ready=1 after that edge.
REQ-024 Reset SHALL take priority over load; reset and load both active at the same edge SHALL leave the block in IDLE with no word accepted.
REQ-025 Reset asserted mid-word SHALL abort the word at the next edge with no done pulse; a reset pulse between edges SHALL have no effect.

Structure
REQ-026 The shared package SHALL hold the state encoding (IDLE=1'b0, SHIFT=1'b1) and the default WIDTH constant.
REQ-027 The single natural sub-module is bit_counter: a synchronous active-low-reset up-counter with clear, enable and a terminal-count flag. The FSM and shift register stay in piso_serializer.
REQ-028 All outputs SHALL be driven directly from flops, with no combinational path from inputs to Q, valid or done.

Verification
REQ-029 Reset: reset=0 for 2 edges with load=1 and din=8'hA5 -> ready=1, valid=0, Q=0, no word accepted.
REQ-030 MSB-first: WIDTH=8, load with din=8'hA5 at edge N -> Q=1,0,1,0,0,1,0,1 in cycles N+1..N+8, valid=1 throughout, done=1 only in N+8, ready=1 in N+9.
REQ-031 LSB-first: MSB_FIRST=0, din=8'h0F -> Q=1,1,1,1,0,0,0,0, done in the 8th bit cycle.
REQ-032 Busy load and din change: load=1 with din=8'hFF during SHIFT of 8'h00 -> eight zeros sent, then the 8'hFF word starts only after ready=1.
REQ-033 Mid-word reset: reset=0 after the 3rd bit of 8'hC3 -> next cycle idle, no done pulse; a new load of 8'h3C then serializes correctly.
REQ-034 Back-to-back: load held high for 40 cycles -> words start every 9 cycles with exactly one idle cycle (valid=0) between words.
